// File: rtl/cotm32_pkg.sv
// Shared RV32 core types: M-extension op encoding and multiply/divide FSM states.
package cotm32_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    function automatic logic muldiv_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// UNROLL iterations of unsigned add-shift multiply, or restoring divide when
// COTM32_MULDIV_DIV_EN is defined. {hi,lo} is product / {remainder,quotient}.
module muldiv_step #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
`ifdef COTM32_MULDIV_DIV_EN
    input  logic            div_i,
`endif
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_v;
    logic [XLEN-1:0] lo_v;
    logic [XLEN:0]   sum;
`ifdef COTM32_MULDIV_DIV_EN
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
`endif

    always_comb begin
        hi_v = hi_i;
        lo_v = lo_i;
        sum  = '0;
`ifdef COTM32_MULDIV_DIV_EN
        shifted = '0;
        diff    = '0;
`endif
        for (int unsigned k = 0; k < UNROLL; k++) begin
`ifdef COTM32_MULDIV_DIV_EN
            if (div_i) begin
                // remainder < divisor, so a negative trial difference shows in bit XLEN
                shifted = {hi_v, lo_v[XLEN-1]};
                diff    = shifted - {1'b0, opnd_i};
                lo_v    = {lo_v[XLEN-2:0], ~diff[XLEN]};
                hi_v    = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            end else
`endif
            begin
                sum  = {1'b0, hi_v} + (lo_v[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
                hi_v = sum[XLEN:1];
                lo_v = {sum[0], lo_v[XLEN-1:1]};
            end
        end
        hi_o = hi_v;
        lo_o = lo_v;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: operand magnitudes are iterated by
// muldiv_step, then sign-fixed. Divider present only with COTM32_MULDIV_DIV_EN.
module muldiv_unit
    import cotm32_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  muldiv_op_t      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_illegal
);

    localparam int unsigned N     = XLEN / UNROLL;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef COTM32_MULDIV_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_result_q, resp_result_d;
    logic            resp_illegal_q, resp_illegal_d;

    logic            a_neg, b_neg, neg_acc;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            fast;
    logic [XLEN-1:0] fast_result;
    logic            fast_illegal;
    logic [XLEN-1:0] step_hi, step_lo;
    logic            sel_hi, carry;
    logic [XLEN-1:0] raw, fixed;

    assign req_ready    = (state_q == IDLE) && !kill;
    assign resp_valid   = resp_valid_q;
    assign resp_result  = resp_result_q;
    assign resp_illegal = resp_illegal_q;

    // Operand signs and magnitudes at accept; the core always iterates unsigned.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (muldiv_is_div(req_op)) begin
            a_neg = !req_op[0] && req_a[XLEN-1];
            b_neg = !req_op[0] && req_b[XLEN-1];
        end else begin
            a_neg = ((req_op == MULH) || (req_op == MULHSU)) && req_a[XLEN-1];
            b_neg = (req_op == MULH) && req_b[XLEN-1];
        end
        mag_a   = a_neg ? -req_a : req_a;
        mag_b   = b_neg ? -req_b : req_b;
        // remainder follows the dividend, everything else the operand sign product
        neg_acc = (req_op[2] && req_op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // Results that need no iteration.
    always_comb begin
`ifdef COTM32_MULDIV_DIV_EN
        fast         = 1'b0;
        fast_result  = '0;
        fast_illegal = 1'b0;
        if (muldiv_is_div(req_op)) begin
            if (req_b == '0) begin
                fast        = 1'b1;
                fast_result = req_op[1] ? req_a : '1;
            end else if (!req_op[0] && (req_a == INT_MIN) && (req_b == '1)) begin
                fast        = 1'b1;
                fast_result = req_op[1] ? '0 : req_a;
            end
        end
`else
        fast         = muldiv_is_div(req_op);
        fast_result  = '0;
        fast_illegal = muldiv_is_div(req_op);
`endif
    end

    muldiv_step #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_step (
`ifdef COTM32_MULDIV_DIV_EN
        .div_i  (op_q[2]),
`endif
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    // Sign fix-up; negating a MULH* high word borrows from the low word.
    always_comb begin
        sel_hi = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
        raw    = sel_hi ? step_hi : step_lo;
        carry  = (sel_hi && !op_q[2]) ? (step_lo == '0) : 1'b1;
        fixed  = neg_q ? (~raw + XLEN'(carry)) : raw;
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        opnd_d         = opnd_q;
        neg_d          = neg_q;
        cnt_d          = cnt_q;
        resp_valid_d   = resp_valid_q;
        resp_result_d  = resp_result_q;
        resp_illegal_d = resp_illegal_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d = req_op;
                    if (fast) begin
                        state_d        = DONE;
                        resp_valid_d   = 1'b1;
                        resp_result_d  = fast_result;
                        resp_illegal_d = fast_illegal;
                    end else begin
                        state_d = BUSY;
                        hi_d    = '0;
                        lo_d    = req_op[2] ? mag_a : mag_b;
                        opnd_d  = req_op[2] ? mag_b : mag_a;
                        neg_d   = neg_acc;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d        = DONE;
                    resp_valid_d   = 1'b1;
                    resp_result_d  = fixed;
                    resp_illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d        = IDLE;
                    resp_valid_d   = 1'b0;
                    resp_illegal_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // kill wins over every transition, including a response handshake
        if (kill) begin
            state_d        = IDLE;
            resp_valid_d   = 1'b0;
            resp_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= MUL;
            hi_q           <= '0;
            lo_q           <= '0;
            opnd_q         <= '0;
            neg_q          <= 1'b0;
            cnt_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_result_q  <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            opnd_q         <= opnd_d;
            neg_q          <= neg_d;
            cnt_q          <= cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_result_q  <= resp_result_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M corner cases, handshake hold, kill,
// reset abort and random ops against a 64-bit arithmetic model.
module tb_muldiv_unit #(
    parameter int unsigned UNROLL = 1
);
    import cotm32_pkg::*;

    localparam int XLEN = 32;
    localparam int N    = XLEN / UNROLL;
`ifdef COTM32_MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    muldiv_op_t  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .kill         (kill),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_illegal (resp_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic with RV32M special cases.
    function automatic void model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint      sa, sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ill = 1'b0;
        lat = N + 1;
        r   = '0;
        p   = '0;
        case (op)
            MUL:    begin p = sa * sb; r = p[31:0]; end
            MULH:   begin p = sa * sb; r = p[63:32]; end
            MULHSU: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
            MULHU:  begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            default: begin
                if (!DIV_ON) begin
                    r = '0; ill = 1'b1; lat = 1;
                end else if (b == 32'h0) begin
                    lat = 1;
                    r = (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
                end else if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    r = (op == DIV) ? a : 32'h0;
                end else begin
                    case (op)
                        DIV:     r = 32'(sa / sb);
                        REM:     r = 32'(sa % sb);
                        DIVU:    r = a / b;
                        default: r = a % b;
                    endcase
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Present one request, confirm it is taken, then scramble the request pins.
    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = muldiv_op_t'(3'($urandom_range(0, 7)));
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_i, input int exp_lat,
                          input string tag);
        int lat;
        resp_ready = 1'b0;
        issue(op, a, b);
        wait_resp(lat);
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles required %0d", tag, lat, exp_lat);
        end
        n_checks++;
        if (resp_result !== exp_r) begin
            n_fail++;
            $display("FAIL %s result: op=%s a=%h b=%h got %h required %h", tag, op.name(), a, b, resp_result, exp_r);
        end
        n_checks++;
        if (resp_illegal !== exp_i) begin
            n_fail++;
            $display("FAIL %s illegal: got %b required %b", tag, resp_illegal, exp_i);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: resp_valid=%b required 0", tag, resp_valid);
        end
    endtask

    task automatic run_model_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                input string tag);
        logic [31:0] r;
        logic        ill;
        int          lat;
        model(op, a, b, r, ill, lat);
        run_op(op, a, b, r, ill, lat, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", resp_valid); end
        n_checks++;
        if (resp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h required 0", resp_result); end
        n_checks++;
        if (resp_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b required 0", resp_illegal); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_directed();
        run_op(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, N + 1, "mul_7_m3");
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, N + 1, "mulh_min");
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, N + 1, "mulhu_max");
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, N + 1, "mulhsu_max");
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFD : 32'h0, !DIV_ON, DIV_ON ? N + 1 : 1, "div_m7_2");
        run_op(REM,  32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFF : 32'h0, !DIV_ON, DIV_ON ? N + 1 : 1, "rem_m7_2");
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_ON ? 32'h8000_0000 : 32'h0, !DIV_ON, 1, "div_ovf");
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, !DIV_ON, 1, "rem_ovf");
        run_op(DIVU, 32'd5, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'h0, !DIV_ON, 1, "divu_by0");
        run_op(REMU, 32'd5, 32'd0, DIV_ON ? 32'd5 : 32'h0, !DIV_ON, 1, "remu_by0");
        run_op(DIVU, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'h0, !DIV_ON, DIV_ON ? N + 1 : 1, "divu_100_7");
        run_op(REMU, 32'd100, 32'd7, DIV_ON ? 32'd2 : 32'h0, !DIV_ON, DIV_ON ? N + 1 : 1, "remu_100_7");
    endtask

    task automatic test_hold();
        logic [31:0] a, b, r;
        logic        ill;
        int          lat;
        a = $urandom;
        b = $urandom;
        model(MULHU, a, b, r, ill, lat);
        issue(MULHU, a, b);
        wait_resp(lat);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_op    = MUL;
            req_a     = $urandom;
            req_b     = $urandom;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_result !== r || resp_illegal !== ill || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b result=%h illegal=%b ready=%b required 1 %h %b 0",
                         i, resp_valid, resp_result, resp_illegal, req_ready, r, ill);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic test_kill();
        int  lat;
        bit  seen;
        issue(MUL, $urandom, $urandom);
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_busy: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        seen = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL kill_no_resp: resp_valid=1 after kill required 0"); end
        run_model_op(MULH, $urandom, $urandom, "after_kill");

        kill = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL kill_idle_ready: got %b required 0", req_ready); end
        kill = 1'b0;

        issue(DIVU, 32'd9, 32'd0);
        wait_resp(lat);
        kill       = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        kill       = 1'b0;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_done: valid=%b illegal=%b required 0 0", resp_valid, resp_illegal);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(MULHU, $urandom, $urandom);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b result=%h required 0 0", resp_valid, resp_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_abandon: resp seen=%b ready=%b required 0 1", seen, req_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_model_op(muldiv_op_t'(3'($urandom_range(0, 7))), pick_operand(), pick_operand(), "random");
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = MUL;
        req_a      = '0;
        req_b      = '0;
        kill       = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_kill();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
